m14k_wsram_rmw: RTL and testbench
=================================

# m14k_wsram_rmw

Parametrised way-select (WS) array with integrated read-modify-write control for the M14K I/D cache. It holds the per-set LRU and dirty state, computes LRU and dirty updates internally from a way-touch request, and reports the replacement victim. It clears the whole array with a hardware init sweep after reset or on request. It sits beside the tag/data arrays in the cache controller, in place of a bare WS SRAM plus external LRU logic.

## Interface
- ASSOC, 4: number of ways, 1..4.
- WAYSIZE, 4: way size in KB, one of 1/2/4/8/16.
- DIRTY_EN, 1: 1 = dirty field present (D-cache), 0 = LRU only (I-cache).
- LINE_IDX_SIZE, 6+log2(WAYSIZE): set index width; depth = 2^LINE_IDX_SIZE.
- WS_WIDTH, DIRTY_EN ? 10 : 6: word layout is [5:0] LRU and [9:6] dirty for ways 3..0.

Ports:
- clk  in  1  clock.
- greset  in  1  reset, asynchronous, active-high.
- init_str  in  1  start a software init sweep.
- busy  out  1  init sweep in progress; requests are ignored.
- req_val  in  1  request valid.
- req_op  in  2  00 read, 01 touch, 10 masked write, 11 reserved (treated as read).
- req_idx  in  LINE_IDX_SIZE  set index.
- req_way  in  2  way for touch/dirty.
- req_dset  in  1  touch: set dirty[req_way].
- req_dclr  in  1  touch: clear dirty[req_way].
- req_wmask  in  WS_WIDTH  bit-write mask for op 10.
- req_wdata  in  WS_WIDTH  write data for op 10.
- rsp_val  out  1  response valid.
- rsp_data  out  WS_WIDTH  set word before this request's modification.
- rsp_victim  out  2  LRU victim way computed from rsp_data.

## Operation
- Storage is a 1R1W array of depth 2^LINE_IDX_SIZE × WS_WIDTH. All writes happen in stage 1, at most one per cycle.
- LRU encoding uses pairwise bits: bit0 (0,1), bit1 (0,2), bit2 (1,2), bit3 (0,3), bit4 (1,3), bit5 (2,3). Bit (i,j)=1 means way i was used more recently than way j.
  - ASSOC=1 uses no bits. ASSOC=2 uses bit0. ASSOC=3 uses bits 0-2. ASSOC=4 uses bits 0-5.
  - Unused bits are written as 0.
- Touch way w: set every pair (w,j) with j>w to 1; clear every pair (i,w) with i<w to 0.
- Victim: the lowest way v with bit(v,j)=0 for all valid j>v and bit(i,v)=1 for all i<v. If no way qualifies, the victim is 0. With ASSOC=1 the victim is always 0.
- Dirty update on touch: req_dclr clears dirty[req_way]; otherwise req_dset sets it. If both are asserted, the clear wins. Dirty bits are ignored when DIRTY_EN=0.
- Op 10 writes new = (old & ~wmask) | (wdata & wmask).
- Op 00 performs no write.
- Init FSM has two states, IDLE and INIT.
  - Reset enters INIT with counter 0.
  - init_str in IDLE enters INIT. init_str while in INIT is ignored.
  - INIT writes 0 to index counter each cycle. It returns to IDLE after writing index 2^LINE_IDX_SIZE-1.
  - busy = (state==INIT).
- A request is accepted when req_val && !busy && !init_str. If init_str and req_val arrive together, init wins and the request is dropped with no response.

## Timing
- Reset values:
  - busy=1, FSM=INIT, counter=0.
  - rsp_val=0, rsp_data=0, rsp_victim=0.
  - stage-1 pending write is invalid.
- Stage 0 (cycle T): accept the request and read the array.
- Stage 1 (cycle T+1): rsp_val=1, rsp_data/rsp_victim valid. The modified word is computed and written at the end of T+1 and is visible in the array from T+2.
- Forwarding: a request accepted at T+1 to the same index as the stage-1 write reads the stage-1 new word, not the array. Back-to-back touches to one set therefore compose correctly. Full throughput is one request per cycle.
- rsp_val is a single-cycle pulse per accepted request. The response values hold until the next response.
- Init sweep takes exactly 2^LINE_IDX_SIZE cycles with busy high. The first request can be accepted in the cycle busy reads 0.
- A stage-1 write pending when init_str is accepted still completes. Its response is still given, and the sweep overwrites the line afterwards.
- greset mid-operation discards the pending write and response and restarts the sweep at index 0.

## Test plan
- Reset with ASSOC=4, LINE_IDX_SIZE=6 -> busy high for exactly 64 cycles. Then read of any index -> rsp_data=0, rsp_victim=0.
- Touch ways 0,1,2,3 on index 5, then read index 5 -> rsp_victim=0. Touch ways 3,2,1,0, then read -> rsp_victim=3.
- Touch way 2 on index 5 from 0 and read index 5 in the next cycle (forwarding) -> rsp_data[5:0]=6'h20, rsp_victim=0. The same value is returned by a read issued two cycles later.
- DIRTY_EN=1:
  - Touch way 1 with dset, then read -> bit7=1.
  - Touch with dset and dclr together -> bit7=0.
  - Op 10 with mask 10'h3C0 and data 0 -> dirty bits cleared, LRU unchanged.
- ASSOC=2: touch way 1 -> rsp of the following read shows [5:0]=0, victim 0. Touch way 0 -> [5:0]=1, victim 1.
- Assert greset during a sweep at counter 30 -> counter restarts at 0 and busy lasts 64 more cycles. init_str together with req_val -> no rsp_val.

Source files
------------

// File: rtl/m14k_wsram_rmw.sv
// Way-select array (per-set LRU + dirty) with built-in read-modify-write and a hardware clear sweep.
// Read at T, respond and write back at T+1; same-set forwarding keeps back-to-back requests coherent.
module m14k_wsram_rmw #(
    parameter int ASSOC         = 4,
    parameter int WAYSIZE       = 4,
    parameter int DIRTY_EN      = 1,
    parameter int LINE_IDX_SIZE = 6 + $clog2(WAYSIZE),
    parameter int WS_WIDTH      = (DIRTY_EN != 0) ? 10 : 6
) (
    input  logic                     clk,
    input  logic                     greset,
    input  logic                     init_str,
    output logic                     busy,
    input  logic                     req_val,
    input  logic [1:0]               req_op,
    input  logic [LINE_IDX_SIZE-1:0] req_idx,
    input  logic [1:0]               req_way,
    input  logic                     req_dset,
    input  logic                     req_dclr,
    input  logic [WS_WIDTH-1:0]      req_wmask,
    input  logic [WS_WIDTH-1:0]      req_wdata,
    output logic                     rsp_val,
    output logic [WS_WIDTH-1:0]      rsp_data,
    output logic [1:0]               rsp_victim
);
    localparam int DEPTH = 1 << LINE_IDX_SIZE;
    localparam int NPAIR = ASSOC * (ASSOC - 1) / 2;
    localparam logic [5:0] LRU_USED = 6'((1 << NPAIR) - 1);

    typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic [LINE_IDX_SIZE-1:0] init_cnt, init_cnt_nxt;

    logic [WS_WIDTH-1:0]      mem [DEPTH];
    logic                     mem_we;
    logic [LINE_IDX_SIZE-1:0] mem_waddr;
    logic [WS_WIDTH-1:0]      mem_wdat;

    logic                     accept, fwd, s1_wen;
    logic [1:0]               s1_op, s1_way;
    logic [LINE_IDX_SIZE-1:0] s1_idx;
    logic                     s1_dset, s1_dclr;
    logic [WS_WIDTH-1:0]      s1_wmask, s1_wdata, s1_new, touch_word;
    logic [5:0]               lru_touch;
    logic                     vic_ok, vic_found;

    // Pair (i,j), i<j, lives at bit j*(j-1)/2+i.
    function automatic logic [2:0] pair_bit(input int i, input int j);
        return 3'(j * (j - 1) / 2 + i);
    endfunction

    assign busy   = (state == INIT);
    assign accept = req_val && !busy && !init_str;

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            IDLE: begin
                if (init_str) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                end
            end
            INIT: begin
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == '1) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        lru_touch = rsp_data[5:0];
        for (int j = 1; j < 4; j++) begin
            for (int i = 0; i < j; i++) begin
                if (s1_way == 2'(i))      lru_touch[pair_bit(i, j)] = 1'b1;
                else if (s1_way == 2'(j)) lru_touch[pair_bit(i, j)] = 1'b0;
            end
        end
    end

    generate
        if (DIRTY_EN != 0) begin : g_dirty
            logic [3:0] dirty_new;
            always_comb begin
                dirty_new = rsp_data[WS_WIDTH-1:6];
                // clear takes priority over set
                if (s1_dclr)      dirty_new[s1_way] = 1'b0;
                else if (s1_dset) dirty_new[s1_way] = 1'b1;
            end
            assign touch_word = {dirty_new, lru_touch};
        end else begin : g_lru_only
            logic unused_dirty;
            assign unused_dirty = s1_dset ^ s1_dclr;
            assign touch_word   = lru_touch;
        end
    endgenerate

    always_comb begin
        s1_new = rsp_data;
        s1_wen = 1'b0;
        case (s1_op)
            2'b01: begin
                s1_new = touch_word;
                s1_wen = rsp_val;
            end
            2'b10: begin
                s1_new = (rsp_data & ~s1_wmask) | (s1_wdata & s1_wmask);
                s1_wen = rsp_val;
            end
            default: ;
        endcase
        s1_new[5:0] = s1_new[5:0] & LRU_USED;
    end

    // The sweep owns the write port; no request can be in stage 1 while in INIT.
    always_comb begin
        mem_we    = busy || s1_wen;
        mem_waddr = busy ? init_cnt : s1_idx;
        mem_wdat  = busy ? '0 : s1_new;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdat;
    end

    assign fwd = s1_wen && (s1_idx == req_idx);

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            rsp_val  <= 1'b0;
            rsp_data <= '0;
            s1_op    <= 2'b00;
            s1_idx   <= '0;
            s1_way   <= 2'b00;
            s1_dset  <= 1'b0;
            s1_dclr  <= 1'b0;
            s1_wmask <= '0;
            s1_wdata <= '0;
        end else begin
            rsp_val <= accept;
            if (accept) begin
                rsp_data <= fwd ? s1_new : mem[req_idx];
                s1_op    <= req_op;
                s1_idx   <= req_idx;
                s1_way   <= req_way;
                s1_dset  <= req_dset;
                s1_dclr  <= req_dclr;
                s1_wmask <= req_wmask;
                s1_wdata <= req_wdata;
            end
        end
    end

    // Victim: lowest valid way that is older than every other valid way.
    always_comb begin
        rsp_victim = 2'd0;
        vic_found  = 1'b0;
        vic_ok     = 1'b0;
        for (int v = 0; v < ASSOC; v++) begin
            vic_ok = 1'b1;
            for (int j = v + 1; j < ASSOC; j++) begin
                if (rsp_data[pair_bit(v, j)]) vic_ok = 1'b0;
            end
            for (int i = 0; i < v; i++) begin
                if (!rsp_data[pair_bit(i, v)]) vic_ok = 1'b0;
            end
            if (vic_ok && !vic_found) begin
                rsp_victim = 2'(v);
                vic_found  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_m14k_wsram_rmw.sv
// Bench for m14k_wsram_rmw: a 4-way D-cache instance and a 2-way I-cache instance driven in lockstep.
module tb_m14k_wsram_rmw;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       greset, init_str, req_val, req_dset, req_dclr;
    logic [1:0] req_op, req_way;
    logic [5:0] req_idx;
    logic [9:0] req_wmask, req_wdata;

    logic       busy1, rsp_val1;
    logic [9:0] rsp_data1;
    logic [1:0] rsp_victim1;
    logic       busy2, rsp_val2;
    logic [5:0] rsp_data2;
    logic [1:0] rsp_victim2;

    m14k_wsram_rmw #(.ASSOC(4), .WAYSIZE(1), .DIRTY_EN(1)) dut (
        .clk(clk), .greset(greset), .init_str(init_str), .busy(busy1),
        .req_val(req_val), .req_op(req_op), .req_idx(req_idx), .req_way(req_way),
        .req_dset(req_dset), .req_dclr(req_dclr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_val(rsp_val1), .rsp_data(rsp_data1), .rsp_victim(rsp_victim1)
    );

    m14k_wsram_rmw #(.ASSOC(2), .WAYSIZE(1), .DIRTY_EN(0)) dut2 (
        .clk(clk), .greset(greset), .init_str(init_str), .busy(busy2),
        .req_val(req_val), .req_op(req_op), .req_idx(req_idx), .req_way(req_way),
        .req_dset(req_dset), .req_dclr(req_dclr), .req_wmask(req_wmask[5:0]), .req_wdata(req_wdata[5:0]),
        .rsp_val(rsp_val2), .rsp_data(rsp_data2), .rsp_victim(rsp_victim2)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] m1 [64];
    logic [5:0] m2 [64];

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] idx;
        logic [1:0] way;
        logic       ds, dc;
        logic [9:0] mask, data;
        logic [9:0] exp;
        logic [1:0] vic;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pbit(input int i, input int j);
        return j * (j - 1) / 2 + i;
    endfunction

    function automatic bit bitof(input logic [9:0] w, input int k);
        return ((w >> k) & 10'd1) != 10'd0;
    endfunction

    // Reference word update: the word as it must look after the request.
    function automatic logic [9:0] mdl_next(input logic [9:0] old, input int assoc, input int dirty_en,
                                            input logic [1:0] op, input int way, input logic ds,
                                            input logic dc, input logic [9:0] mask, input logic [9:0] data);
        logic [9:0] w;
        w = old;
        if (op == 2'b01) begin
            for (int j = way + 1; j < assoc; j++) w = w | (10'd1 << pbit(way, j));
            for (int i = 0; i < way; i++) w = w & ~(10'd1 << pbit(i, way));
            if (dirty_en != 0) begin
                if (dc)      w = w & ~(10'd1 << (6 + way));
                else if (ds) w = w | (10'd1 << (6 + way));
            end
        end else if (op == 2'b10) begin
            w = (old & ~mask) | (data & mask);
        end else begin
            return old;
        end
        for (int k = assoc * (assoc - 1) / 2; k < 6; k++) w = w & ~(10'd1 << k);
        return w;
    endfunction

    function automatic logic [1:0] mdl_victim(input logic [9:0] w, input int assoc);
        bit ok;
        for (int v = 0; v < assoc; v++) begin
            ok = 1'b1;
            for (int j = v + 1; j < assoc; j++) if (bitof(w, pbit(v, j))) ok = 1'b0;
            for (int i = 0; i < v; i++) if (!bitof(w, pbit(i, v))) ok = 1'b0;
            if (ok) return 2'(v);
        end
        return 2'd0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 64; k++) begin
            m1[k] = '0;
            m2[k] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request cycle on both instances, checked against the model.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] idx, input logic [1:0] way,
                       input logic ds, input logic dc, input logic [9:0] mask, input logic [9:0] data,
                       input logic ini);
        logic       acc1, acc2;
        logic [9:0] e1;
        logic [5:0] e2;
        req_val = v; req_op = op; req_idx = idx; req_way = way;
        req_dset = ds; req_dclr = dc; req_wmask = mask; req_wdata = data; init_str = ini;
        acc1 = v && !busy1 && !ini;
        acc2 = v && !busy2 && !ini;
        e1 = m1[idx];
        e2 = m2[idx];
        if (acc1) m1[idx] = mdl_next(e1, 4, 1, op, int'(way), ds, dc, mask, data);
        if (acc2) m2[idx] = 6'(mdl_next({4'b0, e2}, 2, 0, op, int'(way), ds, dc, mask, data));
        if (ini && !busy1) clear_model();
        step();
        req_val = 1'b0;
        init_str = 1'b0;
        chk("rsp_val_a4", {31'b0, rsp_val1}, {31'b0, acc1});
        chk("rsp_val_a2", {31'b0, rsp_val2}, {31'b0, acc2});
        if (acc1) begin
            chk("rsp_data_a4", 32'(rsp_data1), 32'(e1));
            chk("victim_a4", 32'(rsp_victim1), 32'(mdl_victim(e1, 4)));
        end
        if (acc2) begin
            chk("rsp_data_a2", 32'(rsp_data2), 32'(e2));
            chk("victim_a2", 32'(rsp_victim2), 32'(mdl_victim({4'b0, e2}, 2)));
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy1 && n < 300) begin
            n++;
            step();
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [5:0] idx,
                                input logic [1:0] way, input logic ds, input logic dc,
                                input logic [9:0] mask, input logic [9:0] data,
                                input logic [9:0] exp, input logic [1:0] vic);
        vec_t t;
        t.v = v; t.op = op; t.idx = idx; t.way = way; t.ds = ds; t.dc = dc;
        t.mask = mask; t.data = data; t.exp = exp; t.vic = vic;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        greset = 1'b1; init_str = 1'b0; req_val = 1'b0; req_op = 2'b00; req_idx = '0;
        req_way = 2'b00; req_dset = 1'b0; req_dclr = 1'b0; req_wmask = '0; req_wdata = '0;
        clear_model();

        // LRU walks on set 5, dirty handling, masked writes, reserved op, then a forwarding pair on set 9.
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd1, 0, 0, 10'h000, 10'h000, 10'h00B, 2'd1));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd2, 0, 0, 10'h000, 10'h000, 10'h01E, 2'd2));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd3, 0, 0, 10'h000, 10'h000, 10'h038, 2'd3));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd3, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd2, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd1, 0, 0, 10'h000, 10'h000, 10'h020, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h034, 2'd0));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h03F, 2'd3));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd1, 1, 0, 10'h000, 10'h000, 10'h03F, 2'd3));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h0BE, 2'd3));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd1, 1, 1, 10'h000, 10'h000, 10'h0BE, 2'd3));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h03E, 2'd3));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd3, 1, 0, 10'h000, 10'h000, 10'h03E, 2'd3));
        tbl.push_back(mk(1, 2'b01, 6'd5, 2'd0, 1, 0, 10'h000, 10'h000, 10'h206, 2'd2));
        tbl.push_back(mk(1, 2'b10, 6'd5, 2'd0, 0, 0, 10'h3C0, 10'h000, 10'h24F, 2'd2));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h00F, 2'd2));
        tbl.push_back(mk(1, 2'b10, 6'd5, 2'd0, 0, 0, 10'h03F, 10'h02A, 10'h00F, 2'd2));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h02A, 2'd0));
        tbl.push_back(mk(1, 2'b11, 6'd5, 2'd0, 0, 0, 10'h3FF, 10'h3FF, 10'h02A, 2'd0));
        tbl.push_back(mk(1, 2'b00, 6'd5, 2'd0, 0, 0, 10'h000, 10'h000, 10'h02A, 2'd0));
        tbl.push_back(mk(1, 2'b00, 6'd63, 2'd0, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b01, 6'd9, 2'd2, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b00, 6'd9, 2'd0, 0, 0, 10'h000, 10'h000, 10'h020, 2'd0));
        tbl.push_back(mk(0, 2'b00, 6'd9, 2'd0, 0, 0, 10'h000, 10'h000, 10'h000, 2'd0));
        tbl.push_back(mk(1, 2'b00, 6'd9, 2'd0, 0, 0, 10'h000, 10'h000, 10'h020, 2'd0));

        #2;
        chk("reset_busy", {31'b0, busy1}, 32'd1);
        chk("reset_rsp_val", {31'b0, rsp_val1}, 32'd0);
        chk("reset_rsp_data", 32'(rsp_data1), 32'd0);
        chk("reset_victim", 32'(rsp_victim1), 32'd0);
        chk("reset_busy_a2", {31'b0, busy2}, 32'd1);
        step();
        step();
        greset = 1'b0;
        wait_idle(n);
        chk("busy_len_reset", 32'(n), 32'd64);
        chk("busy_a2_after_sweep", {31'b0, busy2}, 32'd0);

        foreach (tbl[k]) begin
            cyc(tbl[k].v, tbl[k].op, tbl[k].idx, tbl[k].way, tbl[k].ds, tbl[k].dc,
                tbl[k].mask, tbl[k].data, 1'b0);
            if (tbl[k].v) begin
                chk($sformatf("tbl%0d_data", k), 32'(rsp_data1), 32'(tbl[k].exp));
                chk($sformatf("tbl%0d_victim", k), 32'(rsp_victim1), 32'(tbl[k].vic));
            end
        end

        // Two-way instance: touching way 1 leaves bit0 clear, touching way 0 sets it.
        cyc(1, 2'b01, 6'd12, 2'd1, 0, 0, 10'h0, 10'h0, 1'b0);
        cyc(1, 2'b00, 6'd12, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);
        chk("a2_after_w1_data", 32'(rsp_data2), 32'd0);
        chk("a2_after_w1_victim", 32'(rsp_victim2), 32'd0);
        cyc(1, 2'b01, 6'd12, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);
        cyc(1, 2'b00, 6'd12, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);
        chk("a2_after_w0_data", 32'(rsp_data2), 32'd1);
        chk("a2_after_w0_victim", 32'(rsp_victim2), 32'd1);

        // Random traffic on a few sets so forwarding is hit often.
        for (int r = 0; r < 600; r++) begin
            cyc(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                10'($urandom), 10'($urandom), 1'b0);
        end

        // Pending write completes and responds; init_str with req_val drops the request.
        cyc(1, 2'b01, 6'd8, 2'd1, 1, 0, 10'h0, 10'h0, 1'b0);
        cyc(1, 2'b00, 6'd8, 2'd0, 0, 0, 10'h0, 10'h0, 1'b1);
        wait_idle(n);
        chk("busy_len_init_str", 32'(n), 32'd64);
        cyc(1, 2'b00, 6'd8, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);
        cyc(1, 2'b00, 6'd2, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);

        // greset while a response is in flight, then again mid-sweep at counter 30.
        cyc(1, 2'b01, 6'd7, 2'd3, 1, 0, 10'h0, 10'h0, 1'b0);
        greset = 1'b1;
        #1;
        chk("greset_drops_rsp", {31'b0, rsp_val1}, 32'd0);
        chk("greset_busy", {31'b0, busy1}, 32'd1);
        step();
        greset = 1'b0;
        clear_model();
        for (int c = 0; c < 30; c++) step();
        chk("busy_at_cnt30", {31'b0, busy1}, 32'd1);
        greset = 1'b1;
        step();
        greset = 1'b0;
        wait_idle(n);
        chk("busy_len_after_mid_reset", 32'(n), 32'd64);
        cyc(1, 2'b00, 6'd7, 2'd0, 0, 0, 10'h0, 10'h0, 1'b0);
        chk("set7_cleared", 32'(rsp_data1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
